// File: rtl/parity_check.sv
// UART-RX parity checker: takes DATA_WIDTH data bits LSB first, then one parity bit.
// It reports a parity mismatch on a registered flag that holds until the next frame completes.
module parity_check #(
    parameter int DATA_WIDTH = 8
) (
    input  logic clk_based_on_prescale,
    input  logic rst,
    input  logic parity_type,
    input  logic sampled_data,
    input  logic parity_check_enable,
    output logic parity_error
);

    localparam int CW = $clog2(DATA_WIDTH + 1);
    localparam logic [CW-1:0] PARITY_SLOT = CW'(DATA_WIDTH);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          acc_q, acc_d;
    logic          parity_error_q, parity_error_d;

    always_comb begin
        // NOTE: every signal gets a default before any branch, so no path leaves one unassigned and no latch is inferred.
        cnt_d          = cnt_q;
        acc_d          = acc_q;
        parity_error_d = parity_error_q;

        if (!parity_check_enable) begin
            // An idle bus throws away any partial frame but keeps the last verdict.
            cnt_d = '0;
            acc_d = 1'b0;
        end else if (cnt_q == PARITY_SLOT) begin
            parity_error_d = acc_q ^ sampled_data ^ parity_type;
            cnt_d          = '0;
            acc_d          = 1'b0;
        end else begin
            acc_d = acc_q ^ sampled_data;
            cnt_d = cnt_q + CW'(1);
        end
    end

    // NOTE: state registers use non-blocking assignments, so every flop samples the pre-edge values.
    always_ff @(posedge clk_based_on_prescale or negedge rst) begin
        if (!rst) begin
            cnt_q          <= '0;
            acc_q          <= 1'b0;
            parity_error_q <= 1'b0;
        end else begin
            cnt_q          <= cnt_d;
            acc_q          <= acc_d;
            parity_error_q <= parity_error_d;
        end
    end

    assign parity_error = parity_error_q;

endmodule

// File: tb/tb_parity_check.sv
// Self-checking bench for parity_check: directed frames, aborts, async reset and random traffic.
// The reference model works on whole frames: error = parity bit != expected parity of the data byte.
module tb_parity_check;

    logic clk_based_on_prescale = 1'b0;
    logic rst                   = 1'b0;
    logic parity_type           = 1'b0;
    logic sampled_data          = 1'b0;
    logic parity_check_enable   = 1'b0;
    logic parity_error;

    int total = 0;
    int bad   = 0;
    logic model_err = 1'b0;

    parity_check #(.DATA_WIDTH(8)) dut (
        .clk_based_on_prescale(clk_based_on_prescale),
        .rst                  (rst),
        .parity_type          (parity_type),
        .sampled_data         (sampled_data),
        .parity_check_enable  (parity_check_enable),
        .parity_error         (parity_error)
    );

    always #5 clk_based_on_prescale = ~clk_based_on_prescale;

    function automatic logic expected_error(input logic [7:0] data, input logic ptype,
                                            input logic pbit);
        int ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(data[i]);
        // Even parity expects a parity bit equal to the number of ones mod 2; odd expects its inverse.
        return pbit != (((ones % 2) == 1) ^ ptype);
    endfunction

    // Drive one bit, let it be consumed on the next rising edge, then return 1 time unit after that edge.
    task automatic send_bit(input logic b, input logic en);
        sampled_data        = b;
        parity_check_enable = en;
        @(posedge clk_based_on_prescale);
        #1;
    endtask

    // A full frame. During the data bits parity_type carries junk_type, to show that only the parity edge samples it.
    task automatic send_frame(input string name, input logic [7:0] data, input logic ptype,
                              input logic pbit, input logic junk_type);
        for (int i = 0; i < 8; i++) begin
            parity_type = junk_type;
            send_bit(data[i], 1'b1);
            total++;
            if (parity_error !== model_err) begin
                bad++;
                $display("FAIL %s hold bit%0d: got %b expected %b", name, i, parity_error, model_err);
            end
        end
        parity_type = ptype;
        send_bit(pbit, 1'b1);
        model_err = expected_error(data, ptype, pbit);
        total++;
        if (parity_error !== model_err) begin
            bad++;
            $display("FAIL %s result: got %b expected %b (data=%h type=%b pbit=%b)",
                     name, parity_error, model_err, data, ptype, pbit);
        end
    endtask

    task automatic test_reset;
        rst = 1'b0;
        repeat (2) @(posedge clk_based_on_prescale);
        #1;
        total++;
        if (parity_error !== 1'b0) begin
            bad++;
            $display("FAIL reset_value: got %b expected 0", parity_error);
        end
        model_err = 1'b0;
        @(negedge clk_based_on_prescale);
        parity_check_enable = 1'b1;
        rst                 = 1'b1;
    endtask

    task automatic test_back_to_back;
        send_frame("b2b_even_ok",  8'hAA, 1'b0, 1'b0, 1'b0);
        send_frame("b2b_odd_ok",   8'hAA, 1'b1, 1'b1, 1'b1);
        send_frame("b2b_even_bad", 8'hAA, 1'b0, 1'b1, 1'b0);
        // The figures below are constants taken from the written frame definitions.
        total++;
        if (parity_error !== 1'b1) begin
            bad++;
            $display("FAIL b2b_final_const: got %b expected 1", parity_error);
        end
        send_frame("odd_01_ok",  8'h01, 1'b1, 1'b0, 1'b1);
        total++;
        if (parity_error !== 1'b0) begin
            bad++;
            $display("FAIL odd_01_const: got %b expected 0", parity_error);
        end
        send_frame("even_01_bad", 8'h01, 1'b0, 1'b0, 1'b0);
        total++;
        if (parity_error !== 1'b1) begin
            bad++;
            $display("FAIL even_01_const: got %b expected 1", parity_error);
        end
    endtask

    task automatic test_abort;
        logic [3:0] partial = 4'b0111;
        // parity_error is 1 at this point, so the hold check below is meaningful.
        for (int i = 0; i < 4; i++) send_bit(partial[i], 1'b1);
        send_bit(1'b0, 1'b0);
        total++;
        if (parity_error !== model_err) begin
            bad++;
            $display("FAIL abort_hold: got %b expected %b", parity_error, model_err);
        end
        send_frame("abort_then_00", 8'h00, 1'b0, 1'b0, 1'b0);
        total++;
        if (parity_error !== 1'b0) begin
            bad++;
            $display("FAIL abort_const: got %b expected 0", parity_error);
        end
    endtask

    task automatic test_async_reset;
        send_frame("pre_reset_bad", 8'h03, 1'b0, 1'b1, 1'b0);
        send_bit(1'b1, 1'b1);
        send_bit(1'b0, 1'b1);
        send_bit(1'b0, 1'b1);
        #2;
        rst = 1'b0;
        #1;
        model_err = 1'b0;
        total++;
        if (parity_error !== 1'b0) begin
            bad++;
            $display("FAIL async_reset_immediate: got %b expected 0", parity_error);
        end
        @(negedge clk_based_on_prescale);
        rst = 1'b1;
        // If the counter or accumulator survived the reset, this frame would be misaligned or give the wrong verdict.
        send_frame("post_reset", 8'h03, 1'b0, 1'b1, 1'b1);
        total++;
        if (parity_error !== 1'b1) begin
            bad++;
            $display("FAIL post_reset_const: got %b expected 1", parity_error);
        end
    endtask

    task automatic test_random;
        for (int f = 0; f < 60; f++) begin
            int kind = int'($urandom_range(0, 3));
            if (kind == 0) begin
                int n = int'($urandom_range(1, 8));
                for (int i = 0; i < n; i++) send_bit(1'($urandom), 1'b1);
                send_bit(1'($urandom), 1'b0);
            end else if (kind == 1) begin
                repeat ($urandom_range(1, 3)) send_bit(1'($urandom), 1'b0);
            end
            if (kind < 2) begin
                total++;
                if (parity_error !== model_err) begin
                    bad++;
                    $display("FAIL rand_idle_hold f%0d: got %b expected %b", f, parity_error, model_err);
                end
            end
            send_frame("rand_frame", 8'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
        end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_abort();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
